obi_rr_arbiter: RTL and testbench
=================================

Name: obi_rr_arbiter

Overview:
- Two-master OBI arbiter that shares the SoC's single unified bus (RAMs, UART, OBI-WB bridge) between the CPU instruction port (master 0) and the CPU data port (master 1).
- Round-robin arbitration with an optional fixed data priority.
- Supports pipelined transactions, up to MAX_OUTSTANDING in flight.
- Routes each response back to its originating master in order, using an ID FIFO.

Parameters:
- ADDR_WIDTH, 32, address width of all OBI ports
- DATA_WIDTH, 32, data width of all OBI ports
- MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (>=1, power of two)
- DATA_PRIORITY, 0, 1 = master 1 always wins a conflict; 0 = round-robin

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  2  per-master request; bit0 = instr, bit1 = data
- m_gnt_o  out  2  per-master grant
- m_rvalid_o  out  2  per-master response valid
- m0_addr_i, m1_addr_i  in  ADDR_WIDTH  master addresses
- m0_we_i, m1_we_i  in  1  write enable (m0_we_i is tied 0 at the top level)
- m0_be_i, m1_be_i  in  DATA_WIDTH/8  byte enables
- m0_wdata_i, m1_wdata_i  in  DATA_WIDTH  write data
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to both masters
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_addr_o  out  ADDR_WIDTH  muxed address
- s_we_o  out  1  muxed write enable
- s_be_o  out  DATA_WIDTH/8  muxed byte enables
- s_wdata_o  out  DATA_WIDTH  muxed write data
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  in-flight count
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. All state is cleared on reset: ID FIFO empty, count 0, last_grant = 1 (so master 0 wins the first conflict), lock cleared, err_o 0.
- Outputs are combinational from state and inputs. With all m_req_i low, every output is 0.
- Handshake: an address phase completes on a cycle with s_req_o && s_gnt_i. The selected master's m_gnt_o equals s_gnt_i; the other master's grant is 0. Adds zero latency on the request path.
- Selection:
  - Only one master requests: it is selected.
  - Both request, DATA_PRIORITY=1: master 1 is selected.
  - Both request, DATA_PRIORITY=0: the master other than last_grant is selected.
  - last_grant updates on each completed handshake.
- Lock: if s_req_o is high and s_gnt_i is low, the current selection is registered and held until the handshake completes. The other master cannot pre-empt, so the address, write data and byte enables stay stable, as OBI requires.
- Capacity: when the count equals MAX_OUTSTANDING, s_req_o = 0 and m_gnt_o = 0. Requests stall and the lock is not set.
- ID FIFO:
  - Each handshake pushes the selected master ID.
  - Each s_rvalid_i pops the head ID; m_rvalid_o[head] = s_rvalid_i the same cycle.
  - m_rdata_o = s_rdata_i unconditionally.
- Response latency equals the slave's latency; there is no added cycle.
- Simultaneous push and pop in the same cycle: the count is unchanged and the FIFO stays coherent. This includes a FIFO that is full and popped in that cycle: the pop frees capacity the same cycle, so a grant is allowed. s_req_o is computed as count < MAX || s_rvalid_i.
- Unexpected s_rvalid_i while the count is 0: err_o is set (sticky until reset), no m_rvalid_o asserts, and there is no pop.
- Reset mid-transaction: all in-flight responses are dropped. Any later stray s_rvalid_i sets err_o.
- Count width arithmetic is unsigned and never wraps, guaranteed by the capacity gate.

Decomposition:
- Shared package soc_bus_pkg:
  - typedef enum logic [0:0] {MST_INSTR=1'b0, MST_DATA=1'b1} master_id_t
  - OBI address/data width constants
  - SoC block-select constants (DRAM=0, IRAM=1, WB=3) for reuse
- Sub-module obi_id_fifo: synchronous FIFO of master_id_t, depth MAX_OUTSTANDING. Ports push/pop/head/count/full/empty; async active-low reset.

Test Plan:
- Single read, m_req_i=01, addr 0x00100000, s_gnt_i=1 at cycle 0, s_rvalid_i at cycle 1 with rdata 0xDEADBEEF -> m_gnt_o=01 at cycle 0; m_rvalid_o=01 and m_rdata_o=0xDEADBEEF at cycle 1; outstanding_o returns to 0.
- Conflict round-robin, DATA_PRIORITY=0, m_req_i=11 held, s_gnt_i=1 always -> grants alternate 01,10,01,10. With DATA_PRIORITY=1 -> 10 every cycle.
- Lock, m_req_i=01 with s_gnt_i=0 for 3 cycles, m1 raises req at cycle 1 -> s_addr_o stays m0_addr_i; m_gnt_o=01 on the cycle s_gnt_i rises; m1 is served next.
- Capacity, MAX_OUTSTANDING=2, two handshakes with no rvalid -> s_req_o=0 and outstanding_o=2. Same cycle s_rvalid_i=1 and req -> grant allowed, outstanding_o stays 2.
- Ordering, handshakes m0 then m1, two s_rvalid_i pulses with 0x11 then 0x22 -> m_rvalid_o=01 with 0x11, then 10 with 0x22.
- Error/reset, s_rvalid_i=1 with outstanding_o=0 -> err_o=1 next cycle, m_rvalid_o=00. Assert rst_ni=0 with 1 outstanding -> outstanding_o=0 and err_o=0 immediately.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC unified OBI bus: master IDs, bus widths and
// block-select codes used by the address decoder.
package soc_bus_pkg;

  localparam int OBI_ADDR_WIDTH = 32;
  localparam int OBI_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } master_id_t;

  localparam logic [1:0] BLK_DRAM = 2'd0;
  localparam logic [1:0] BLK_IRAM = 2'd1;
  localparam logic [1:0] BLK_WB   = 2'd3;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle between the two CPU OBI masters, the arbiter and the shared slave.
// Handshake: an address phase completes on any cycle where req && gnt are both
// high; req and its payload stay stable until then. rvalid is a one-cycle pulse.
interface obi_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              m_req_i;
    logic [1:0]              m_gnt_o;
    logic [1:0]              m_rvalid_o;
    logic [ADDR_WIDTH-1:0]   m0_addr_i;
    logic [ADDR_WIDTH-1:0]   m1_addr_i;
    logic                    m0_we_i;
    logic                    m1_we_i;
    logic [DATA_WIDTH/8-1:0] m0_be_i;
    logic [DATA_WIDTH/8-1:0] m1_be_i;
    logic [DATA_WIDTH-1:0]   m0_wdata_i;
    logic [DATA_WIDTH-1:0]   m1_wdata_i;
    logic [DATA_WIDTH-1:0]   m_rdata_o;
    logic                    s_req_o;
    logic                    s_gnt_i;
    logic [ADDR_WIDTH-1:0]   s_addr_o;
    logic                    s_we_o;
    logic [DATA_WIDTH/8-1:0] s_be_o;
    logic [DATA_WIDTH-1:0]   s_wdata_o;
    logic                    s_rvalid_i;
    logic [DATA_WIDTH-1:0]   s_rdata_i;

    // Arbiter view: takes master requests, drives the shared slave port.
    modport slave (
        input  m_req_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
               m0_be_i, m1_be_i, m0_wdata_i, m1_wdata_i,
               s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
               s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

    // Environment view: CPU masters plus the downstream slave.
    modport master (
        output m_req_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
               m0_be_i, m1_be_i, m0_wdata_i, m1_wdata_i,
               s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
               s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );
endinterface

// File: rtl/obi_rr_arbiter_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered transactions.
// Push while full is only honoured when a pop happens in the same cycle.
module obi_id_fifo
    import soc_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  master_id_t               push_id,
    input  logic                     pop,
    output master_id_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    master_id_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/obi_rr_arbiter.sv
// Two-master OBI arbiter (instr = master 0, data = master 1) in front of the
// unified SoC bus; round-robin or fixed data priority, in-order response routing.
module obi_rr_arbiter
    import soc_bus_pkg::*;
#(
    parameter int ADDR_WIDTH      = OBI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = OBI_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIORITY   = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    obi_rr_arbiter_if.slave                    bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    master_id_t              sel;
    master_id_t              last_grant;
    master_id_t              lock_id;
    master_id_t              head_id;
    logic                    locked;
    logic                    sel_req;
    logic                    cap_ok;
    logic                    s_req;
    logic                    hs;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_be;
    logic                    sel_we;

    // A stalled request keeps its owner so the other master cannot swap the
    // address phase out from under the slave.
    always_comb begin
        sel = MST_INSTR;
        if (locked) begin
            sel = lock_id;
        end else begin
            case (bus.m_req_i)
                2'b10:   sel = MST_DATA;
                2'b11:   sel = (DATA_PRIORITY != 0)   ? MST_DATA :
                               (last_grant == MST_INSTR) ? MST_DATA : MST_INSTR;
                default: sel = MST_INSTR;
            endcase
        end
    end

    assign sel_req = (sel == MST_DATA) ? bus.m_req_i[1] : bus.m_req_i[0];
    // A response in this cycle frees a slot, so a full FIFO can still accept.
    assign cap_ok  = !fifo_full || bus.s_rvalid_i;
    assign s_req   = sel_req && cap_ok;
    assign hs      = s_req && bus.s_gnt_i;
    assign pop     = bus.s_rvalid_i && !fifo_empty;

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        if (sel_req) begin
            if (sel == MST_DATA) begin
                sel_addr  = bus.m1_addr_i;
                sel_we    = bus.m1_we_i;
                sel_be    = bus.m1_be_i;
                sel_wdata = bus.m1_wdata_i;
            end else begin
                sel_addr  = bus.m0_addr_i;
                sel_we    = bus.m0_we_i;
                sel_be    = bus.m0_be_i;
                sel_wdata = bus.m0_wdata_i;
            end
        end
    end

    assign bus.s_req_o    = s_req;
    assign bus.s_addr_o   = sel_addr;
    assign bus.s_we_o     = sel_we;
    assign bus.s_be_o     = sel_be;
    assign bus.s_wdata_o  = sel_wdata;
    assign bus.m_gnt_o    = {hs && (sel == MST_DATA), hs && (sel == MST_INSTR)};
    assign bus.m_rvalid_o = {pop && (head_id == MST_DATA), pop && (head_id == MST_INSTR)};
    assign bus.m_rdata_o  = bus.s_rdata_i;
    assign outstanding_o  = fifo_count;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (hs),
        .push_id (sel),
        .pop     (pop),
        .head    (head_id),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked     <= 1'b0;
            lock_id    <= MST_INSTR;
            last_grant <= MST_DATA;
            err_o      <= 1'b0;
        end else begin
            locked  <= s_req && !bus.s_gnt_i;
            lock_id <= sel;
            if (hs) last_grant <= sel;
            if (bus.s_rvalid_i && fifo_empty) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed/randomised bench for obi_rr_arbiter: round-robin instance plus a
// data-priority instance sharing the same stimulus; responses scoreboarded.
module tb_obi_rr_arbiter;
  import soc_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int CW = $clog2(MO) + 1;
  localparam int W  = DW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  obi_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  logic [CW-1:0] outstanding, outstanding1;
  logic          err, err1;

  obi_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .DATA_PRIORITY(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .outstanding_o(outstanding), .err_o(err));
  obi_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .DATA_PRIORITY(1)) dut_prio (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1), .outstanding_o(outstanding1), .err_o(err1));

  assign bus1.m_req_i    = bus.m_req_i;
  assign bus1.m0_addr_i  = bus.m0_addr_i;
  assign bus1.m1_addr_i  = bus.m1_addr_i;
  assign bus1.m0_we_i    = bus.m0_we_i;
  assign bus1.m1_we_i    = bus.m1_we_i;
  assign bus1.m0_be_i    = bus.m0_be_i;
  assign bus1.m1_be_i    = bus.m1_be_i;
  assign bus1.m0_wdata_i = bus.m0_wdata_i;
  assign bus1.m1_wdata_i = bus.m1_wdata_i;
  assign bus1.s_gnt_i    = bus.s_gnt_i;
  assign bus1.s_rvalid_i = bus.s_rvalid_i;
  assign bus1.s_rdata_i  = bus.s_rdata_i;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [AW-1:0] a0, a1;

  // ---------------- clock/reset and drivers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.m_req_i = 2'b00; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs change on the falling edge; checks run #1 later, before the rising edge.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv);
    @(negedge clk);
    bus.m_req_i    = req;
    bus.s_gnt_i    = gnt;
    bus.s_rvalid_i = rv;
    bus.s_rdata_i  = (rv && exp_q.size() != 0) ? exp_q[0][DW-1:0] : DW'($urandom);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.s_rvalid_i && exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.m_rvalid_o, bus.m_rdata_o} !== e) begin
        failures++;
        $display("FAIL resp: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                 bus.m_rvalid_o, bus.m_rdata_o, e[W-1:DW], e[DW-1:0]);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({bus.s_req_o, bus.m_gnt_o, bus.m_rvalid_o, bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o} !== '0) begin
      failures++;
      $display("FAIL reset_idle: s_req=%b gnt=%b rvalid=%b addr=%h, want all 0",
               bus.s_req_o, bus.m_gnt_o, bus.m_rvalid_o, bus.s_addr_o);
    end
    checks++;
    if (outstanding !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: outstanding=%0d err=%b, want 0 0", outstanding, err);
    end
  endtask

  task automatic test_single_read();
    bus.m0_addr_i = 32'h0010_0000; bus.m0_be_i = 4'hf; bus.m0_we_i = 1'b0;
    bus.m0_wdata_i = DW'($urandom);
    drive(2'b01, 1'b1, 1'b0);
    checks++;
    if (bus.m_gnt_o !== 2'b01 || bus.s_req_o !== 1'b1 || bus.s_addr_o !== 32'h0010_0000) begin
      failures++;
      $display("FAIL single_gnt: gnt=%b req=%b addr=%h, want 01 1 00100000",
               bus.m_gnt_o, bus.s_req_o, bus.s_addr_o);
    end
    exp_q.push_back({2'b01, 32'hDEADBEEF});
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (outstanding !== CW'(1)) begin
      failures++;
      $display("FAIL single_inflight: outstanding=%0d, want 1", outstanding);
    end
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL single_drain: outstanding=%0d, want 0", outstanding);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    a0 = AW'($urandom); a1 = ~a0;
    bus.m0_addr_i = a0; bus.m1_addr_i = a1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      drive(2'b11, 1'b1, (i > 0));
      checks++;
      if (bus.m_gnt_o !== exp_g || bus.s_addr_o !== ((i % 2 == 1) ? a1 : a0)) begin
        failures++;
        $display("FAIL rr_gnt[%0d]: gnt=%b addr=%h, want %b %h", i, bus.m_gnt_o, bus.s_addr_o,
                 exp_g, (i % 2 == 1) ? a1 : a0);
      end
      checks++;
      if (bus1.m_gnt_o !== 2'b10) begin
        failures++;
        $display("FAIL prio_gnt[%0d]: gnt=%b, want 10", i, bus1.m_gnt_o);
      end
      exp_q.push_back({exp_g, DW'($urandom)});
    end
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL rr_drain: outstanding=%0d, want 0", outstanding);
    end
  endtask

  task automatic test_lock();
    a0 = AW'($urandom_range(32'h0000_1000, 32'h0000_1fff));
    a1 = AW'($urandom_range(32'h0000_2000, 32'h0000_2fff));
    bus.m0_addr_i = a0; bus.m1_addr_i = a1; bus.m1_we_i = 1'b1;
    drive(2'b01, 1'b1, 1'b0);              // leaves last_grant at master 0
    exp_q.push_back({2'b01, DW'($urandom)});
    drive(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0);
      checks++;
      if (bus.s_addr_o !== a0 || bus.s_we_o !== 1'b0 || bus.m_gnt_o !== 2'b00 || bus.s_req_o !== 1'b1) begin
        failures++;
        $display("FAIL lock_hold[%0d]: addr=%h we=%b gnt=%b req=%b, want %h 0 00 1",
                 i, bus.s_addr_o, bus.s_we_o, bus.m_gnt_o, bus.s_req_o, a0);
      end
    end
    drive(2'b11, 1'b1, 1'b0);
    checks++;
    if (bus.m_gnt_o !== 2'b01 || bus.s_addr_o !== a0) begin
      failures++;
      $display("FAIL lock_release: gnt=%b addr=%h, want 01 %h", bus.m_gnt_o, bus.s_addr_o, a0);
    end
    exp_q.push_back({2'b01, DW'($urandom)});
    drive(2'b11, 1'b1, 1'b1);
    checks++;
    if (bus.m_gnt_o !== 2'b10 || bus.s_addr_o !== a1 || bus.s_we_o !== 1'b1) begin
      failures++;
      $display("FAIL lock_next: gnt=%b addr=%h we=%b, want 10 %h 1", bus.m_gnt_o, bus.s_addr_o, bus.s_we_o, a1);
    end
    exp_q.push_back({2'b10, DW'($urandom)});
    drive(2'b00, 1'b0, 1'b1);
    bus.m1_we_i = 1'b0;
  endtask

  task automatic test_capacity();
    drive(2'b01, 1'b1, 1'b0);
    exp_q.push_back({2'b01, DW'($urandom)});
    drive(2'b10, 1'b1, 1'b0);
    checks++;
    if (bus.m_gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL cap_fill: gnt=%b, want 10", bus.m_gnt_o);
    end
    exp_q.push_back({2'b10, DW'($urandom)});
    drive(2'b01, 1'b1, 1'b0);
    checks++;
    if (bus.s_req_o !== 1'b0 || bus.m_gnt_o !== 2'b00 || outstanding !== CW'(2)) begin
      failures++;
      $display("FAIL cap_full: req=%b gnt=%b outstanding=%0d, want 0 00 2", bus.s_req_o, bus.m_gnt_o, outstanding);
    end
    drive(2'b01, 1'b1, 1'b1);
    checks++;
    if (bus.s_req_o !== 1'b1 || bus.m_gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL cap_pushpop: req=%b gnt=%b, want 1 01", bus.s_req_o, bus.m_gnt_o);
    end
    exp_q.push_back({2'b01, DW'($urandom)});
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (outstanding !== CW'(2)) begin
      failures++;
      $display("FAIL cap_count: outstanding=%0d, want 2", outstanding);
    end
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL cap_drain: outstanding=%0d, want 0", outstanding);
    end
  endtask

  task automatic test_ordering();
    drive(2'b01, 1'b1, 1'b0);
    exp_q.push_back({2'b01, 32'h0000_0011});
    drive(2'b10, 1'b1, 1'b0);
    exp_q.push_back({2'b10, 32'h0000_0022});
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (outstanding !== '0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL order_drain: outstanding=%0d pending=%0d, want 0 0", outstanding, exp_q.size());
    end
  endtask

  task automatic test_error_reset();
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (bus.m_rvalid_o !== 2'b00 || err !== 1'b0) begin
      failures++;
      $display("FAIL err_stray: rvalid=%b err=%b, want 00 0", bus.m_rvalid_o, err);
    end
    drive(2'b00, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || outstanding !== '0) begin
      failures++;
      $display("FAIL err_sticky: err=%b outstanding=%0d, want 1 0", err, outstanding);
    end
    drive(2'b01, 1'b1, 1'b0);
    exp_q.push_back({2'b01, DW'($urandom)});
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (outstanding !== CW'(1)) begin
      failures++;
      $display("FAIL rst_inflight: outstanding=%0d, want 1", outstanding);
    end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (outstanding !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: outstanding=%0d err=%b, want 0 0", outstanding, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 1'b0, 1'b1);
    checks++;
    if (bus.m_rvalid_o !== 2'b00) begin
      failures++;
      $display("FAIL rst_stray: rvalid=%b, want 00", bus.m_rvalid_o);
    end
    drive(2'b00, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL rst_err: err=%b, want 1", err);
    end
  endtask

  initial begin
    bus.m_req_i = 2'b00; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;
    bus.m0_addr_i = '0; bus.m1_addr_i = '0; bus.m0_we_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m0_be_i = 4'hf; bus.m1_be_i = 4'h3;
    bus.m0_wdata_i = '0; bus.m1_wdata_i = DW'($urandom);
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_capacity();
    test_ordering();
    test_error_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_empty: pending=%0d, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
